// File: rtl/mont_exp_param.sv
// Modular exponentiation x^e mod m by left-to-right square-and-multiply.
// A single shared radix-2 Montgomery multiplier (R = 2^N) performs every product.
module mont_exp_param #(
    parameter int N       = 512,
    parameter int E_WIDTH = 512
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [N-1:0]       x,
    input  logic [N-1:0]       modulus,
    input  logic [E_WIDTH-1:0] exponent,
    input  logic [N-1:0]       Rmodm,
    input  logic [N-1:0]       Rsquaredmodm,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       result
);
    localparam int KW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam int CW = $clog2(N + 2);
    localparam logic [KW-1:0] K_TOP  = KW'(E_WIDTH - 1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SCAN, S_ZSCAN, S_SQR, S_MUL, S_POST, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       x_q, x_d, m_q, m_d, r2_q, r2_d;
    logic [N-1:0]       a_q, a_d, xt_q, xt_d, res_q, res_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       sh_q, sh_d;
    logic [N+1:0]       t_q, t_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [N-1:0] mm_a_s, mm_b_s, mm_res_s;
    logic [N+1:0] t_add_s, t_red_s;
    logic         in_mm_s, mm_last_s, e_bit_s, t_ge_s;

    assign in_mm_s   = (state_q == S_PRE) || (state_q == S_SQR) ||
                       (state_q == S_MUL) || (state_q == S_POST);
    assign mm_last_s = (cnt_q == C_LAST);
    assign e_bit_s   = e_q[k_q];
    assign t_add_s   = t_q + (sh_q[0] ? {2'b00, mm_b_s} : {(N+2){1'b0}});
    assign t_red_s   = t_add_s + (t_add_s[0] ? {2'b00, m_q} : {(N+2){1'b0}});
    // T stays below 2m, so one conditional subtract in N bits lands in [0, m)
    assign t_ge_s    = (t_q >= {2'b00, m_q});
    assign mm_res_s  = t_ge_s ? (t_q[N-1:0] - m_q) : t_q[N-1:0];

    // Multiplier operand selection for the current product
    always_comb begin
        mm_a_s = a_q;
        mm_b_s = a_q;
        case (state_q)
            S_PRE: begin
                mm_a_s = x_q;
                mm_b_s = r2_q;
            end
            S_MUL:   mm_b_s = xt_q;
            S_POST:  mm_b_s = {{(N-1){1'b0}}, 1'b1};
            default: mm_b_s = a_q;
        endcase
    end

    // Montgomery multiplier sequencing: load, N iterations, final subtract
    always_comb begin
        t_d   = t_q;
        sh_d  = sh_q;
        cnt_d = C_ZERO;
        if (in_mm_s && !abort) begin
            if (cnt_q == C_ZERO) begin
                t_d   = {(N+2){1'b0}};
                sh_d  = mm_a_s;
                cnt_d = cnt_q + C_ONE;
            end else if (!mm_last_s) begin
                t_d   = t_red_s >> 1'b1;
                sh_d  = sh_q >> 1'b1;
                cnt_d = cnt_q + C_ONE;
            end else begin
                cnt_d = C_ZERO;
            end
        end else begin
            cnt_d = C_ZERO;
        end
    end

    // Exponentiation control and operand capture
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        m_d     = m_q;
        r2_d    = r2_q;
        e_d     = e_q;
        k_d     = k_q;
        a_d     = a_q;
        xt_d    = xt_q;
        res_d   = res_q;
        if (abort && busy_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        x_d     = x;
                        m_d     = modulus;
                        r2_d    = Rsquaredmodm;
                        e_d     = exponent;
                        a_d     = Rmodm;
                        k_d     = K_TOP;
                        state_d = S_PRE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRE: begin
                    if (mm_last_s) begin
                        xt_d    = mm_res_s;
                        state_d = (e_q == {E_WIDTH{1'b0}}) ? S_ZSCAN : S_SCAN;
                    end else begin
                        state_d = S_PRE;
                    end
                end
                S_SCAN: begin
                    if (e_bit_s) begin
                        state_d = S_SQR;
                    end else begin
                        k_d = k_q - K_ONE;
                    end
                end
                S_ZSCAN: begin
                    if (k_q == K_ZERO) begin
                        state_d = S_POST;
                    end else begin
                        k_d = k_q - K_ONE;
                    end
                end
                S_SQR: begin
                    if (mm_last_s) begin
                        a_d = mm_res_s;
                        if (e_bit_s) begin
                            state_d = S_MUL;
                        end else if (k_q == K_ZERO) begin
                            state_d = S_POST;
                        end else begin
                            k_d = k_q - K_ONE;
                        end
                    end else begin
                        state_d = S_SQR;
                    end
                end
                S_MUL: begin
                    if (mm_last_s) begin
                        a_d = mm_res_s;
                        if (k_q == K_ZERO) begin
                            state_d = S_POST;
                        end else begin
                            k_d     = k_q - K_ONE;
                            state_d = S_SQR;
                        end
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_POST: begin
                    if (mm_last_s) begin
                        a_d     = mm_res_s;
                        res_d   = mm_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_POST;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            m_q     <= '0;
            r2_q    <= '0;
            e_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            xt_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= m_d;
            r2_q    <= r2_d;
            e_q     <= e_d;
            k_q     <= k_d;
            a_q     <= a_d;
            xt_q    <= xt_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
endmodule
